// File: rtl/fl_multi_if.sv
// Allocation/retire/commit bus between the rename stage and the physical-register free list.
interface fl_multi_if #(
  parameter int unsigned NUM_PREGS = 96,
  parameter int unsigned NUM_AREGS = 32,
  parameter int unsigned DISP_W    = 2,
  parameter int unsigned RET_W     = 2,
  parameter int unsigned TAG_W     = 7
);
  localparam int unsigned D  = NUM_PREGS - NUM_AREGS;
  localparam int unsigned CW = $clog2(D + 1);
  localparam int unsigned MW = (DISP_W > RET_W) ? DISP_W : RET_W;
  localparam int unsigned NW = $clog2(MW + 1);

  logic [NW-1:0]           dispatch_num;
  logic [NW-1:0]           retire_num;
  logic [RET_W*TAG_W-1:0]  retire_tags;
  logic [NW-1:0]           commit_alloc_num;
  logic                    flush;
  logic [DISP_W*TAG_W-1:0] alloc_tags;
  logic [DISP_W-1:0]       alloc_valid;
  logic                    fl_stall;
  logic [CW-1:0]           free_cnt;

  modport master (
    output dispatch_num, retire_num, retire_tags, commit_alloc_num, flush,
    input  alloc_tags, alloc_valid, fl_stall, free_cnt
  );

  modport slave (
    input  dispatch_num, retire_num, retire_tags, commit_alloc_num, flush,
    output alloc_tags, alloc_valid, fl_stall, free_cnt
  );
endinterface

// File: rtl/fl_multi.sv
// Multi-ported circular free list of physical register tags with speculative
// allocation, commit tracking and flush rollback to the committed head.
module fl_multi #(
  parameter int unsigned NUM_PREGS = 96,
  parameter int unsigned NUM_AREGS = 32,
  parameter int unsigned DISP_W    = 2,
  parameter int unsigned RET_W     = 2,
  parameter int unsigned TAG_W     = 7
) (
  input logic       clock,
  input logic       reset,
  fl_multi_if.slave fl
);
  localparam int unsigned D  = NUM_PREGS - NUM_AREGS;
  localparam int unsigned CW = $clog2(D + 1);
  localparam int unsigned MW = (DISP_W > RET_W) ? DISP_W : RET_W;
  localparam int unsigned NW = $clog2(MW + 1);
  localparam int unsigned PW = (D > 1) ? $clog2(D) : 1;

  logic [TAG_W-1:0] entry [D];
  logic [PW-1:0]    head;
  logic [PW-1:0]    chead;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [CW-1:0]    spec_cnt;

  logic                    grant;
  logic [NW-1:0]           granted_num;
  logic [DISP_W*TAG_W-1:0] alloc_tags_c;
  logic [DISP_W-1:0]       alloc_valid_c;
  logic                    fl_stall_c;

  // Pointer advance modulo D; a single conditional subtract covers any step below D.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [NW-1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(n);
    if (s >= (PW+1)'(D)) s = s - (PW+1)'(D);
    return s[PW-1:0];
  endfunction

  // Grant decision and same-cycle tag presentation from start-of-cycle state.
  always_comb begin
    grant         = 1'b0;
    granted_num   = '0;
    alloc_tags_c  = '0;
    alloc_valid_c = '0;
    fl_stall_c    = 1'b0;
    if (!reset && fl.dispatch_num != '0) begin
      if (!fl.flush && CW'(fl.dispatch_num) <= count) grant = 1'b1;
      fl_stall_c = !grant;
    end
    if (grant) begin
      granted_num = fl.dispatch_num;
      for (int unsigned k = 0; k < DISP_W; k++) begin
        if (NW'(k) < fl.dispatch_num) begin
          alloc_tags_c[k*TAG_W +: TAG_W] = entry[ptr_add(head, NW'(k))];
          alloc_valid_c[k]               = 1'b1;
        end
      end
    end
  end

  assign fl.alloc_tags  = alloc_tags_c;
  assign fl.alloc_valid = alloc_valid_c;
  assign fl.fl_stall    = fl_stall_c;
  assign fl.free_cnt    = count;

  // Retired tags land at the tail; they are only visible to allocation next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < D; i++) entry[i] <= TAG_W'(NUM_AREGS + i);
    end else begin
      for (int unsigned k = 0; k < RET_W; k++) begin
        if (NW'(k) < fl.retire_num)
          entry[ptr_add(tail, NW'(k))] <= fl.retire_tags[k*TAG_W +: TAG_W];
      end
    end
  end

  // Pointer and counter state; flush rewinds head to the post-commit chead.
  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      chead    <= '0;
      tail     <= '0;
      count    <= CW'(D);
      spec_cnt <= '0;
    end else begin
      tail  <= ptr_add(tail, fl.retire_num);
      chead <= ptr_add(chead, fl.commit_alloc_num);
      if (fl.flush) begin
        head     <= ptr_add(chead, fl.commit_alloc_num);
        count    <= count + spec_cnt - CW'(fl.commit_alloc_num) + CW'(fl.retire_num);
        spec_cnt <= '0;
      end else begin
        head     <= ptr_add(head, granted_num);
        count    <= count - CW'(granted_num) + CW'(fl.retire_num);
        spec_cnt <= spec_cnt + CW'(granted_num) - CW'(fl.commit_alloc_num);
      end
    end
  end

`ifndef SYNTHESIS
  // Protocol violations from the pipeline; the list does not try to recover.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (fl.dispatch_num <= NW'(DISP_W));
      assert (fl.retire_num <= NW'(RET_W));
      assert (int'(count) + int'(fl.retire_num) - int'(granted_num) <= int'(D));
      assert (int'(fl.commit_alloc_num) <= int'(spec_cnt) + int'(granted_num));
    end
  end
`endif

endmodule
